core_ibex_event_recorder: RTL and testbench
===========================================

Name: core_ibex_event_recorder

Overview:
Parametrised successor to the DUT probe interface. It samples a vector of single-cycle core event strobes (illegal_instr, ecall, wfi, ebreak, dret, mret, ...) together with the current privilege mode. It keeps per-channel saturating counters and sticky flags, and pushes time-stamped event records into a FIFO drained by the DV monitor through a valid/ready handshake. It sits in the DV env, bound beside the core, so scoreboards never miss back-to-back events.

Parameters:
NUM_EVT, 8, number of event channels (1..32)
CNT_W, 16, width of each per-channel event counter
DEPTH, 8, record FIFO depth; power of 2, >= 2
TS_W, 32, width of the free-running timestamp

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
evt_i  input  NUM_EVT  event strobes, one bit per channel, sampled every clk rising edge
priv_mode_i  input  2  current ibex_pkg::priv_lvl_e value
clr_i  input  1  synchronous clear of counters, sticky flags and drop count
rec_valid_o  output  1  FIFO head record valid
rec_ready_i  input  1  consumer accepts head record
rec_evt_o  output  NUM_EVT  head record event vector
rec_ts_o  output  TS_W  head record timestamp
rec_priv_o  output  2  head record privilege mode
cnt_o  output  NUM_EVT*CNT_W  per-channel counters; channel k in bits [k*CNT_W +: CNT_W]
seen_o  output  NUM_EVT  sticky "event occurred since clear" flags
drop_cnt_o  output  CNT_W  number of records lost to a full FIFO
level_o  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Interface decision: one clock, clk. Reset is reset, asynchronous and active-high. All outputs and state are 0 while reset is high. The FIFO is empty after reset.
- Timestamp: TS_W counter. 0 in the first cycle after reset release, +1 every cycle, wraps all-ones -> 0. It is not affected by clr_i.
- Push: a record is generated in any cycle where evt_i != 0.
  - Record contents: {evt_i, ts, priv_mode_i} as sampled in that same cycle.
  - Multiple simultaneous bits form one record.
- Pop: occurs when rec_valid_o & rec_ready_i.
  - rec_*_o show the head entry combinationally from storage.
  - rec_valid_o = (level_o != 0).
  - rec_ready_i while empty has no effect.
- Latency: an event at edge N gives rec_valid_o = 1 after edge N, with the record visible in cycle N+1 (when previously empty).
- Full FIFO:
  - Push without a same-cycle pop: the record is dropped, and drop_cnt_o increments, saturating at all-ones.
  - Push with a same-cycle pop: both complete and level is unchanged.
- Empty FIFO: a push and pop in the same cycle is impossible, because valid was 0. The push is accepted.
- Pointers: wrap modulo DEPTH. level_o ranges 0..DEPTH.
- Counters: cnt[k] += 1 when evt_i[k], saturating at 2^CNT_W-1 (no wrap). seen[k] sets on evt_i[k].
- clr_i:
  - Zeros cnt, seen and drop_cnt.
  - Clear wins over a same-cycle increment: the counter reads 0, not 1.
  - A drop coinciding with clr_i leaves drop_cnt at 0.
  - clr_i does not flush the FIFO. An event in the clear cycle is still pushed.
- Reset mid-operation: the FIFO contents are discarded, everything returns to 0, and the timestamp restarts.
- Unknown (X) on evt_i is a bench error. An immediate assertion flags it in simulation.

Optional Feature:
Macro: CORE_IBEX_EVT_PRIV_TRACK_EN.
- When defined:
  - A change of priv_mode_i relative to its previous-cycle value counts as an implicit event.
  - A record is pushed with rec_evt_o = 0 and rec_priv_o = the new mode, through the same full/drop rules.
  - If the change coincides with real events, there is one record: the real event bits plus the new mode.
  - The first cycle after reset never counts as a change; the previous value resets to 0 (U-mode).
- When undefined: priv changes generate nothing, and records are pushed only when evt_i != 0.

Test Plan:
- Single event: reset, then after 5 cycles pulse evt_i=8'h04 with priv=3 -> next cycle rec_valid_o=1, rec_evt_o=8'h04, rec_ts_o=5, rec_priv_o=3; cnt[2]=1, seen_o=8'h04, level_o=1.
- Overflow: rec_ready_i=0, pulse evt_i=8'h01 for 10 cycles with DEPTH=8 -> level_o=8, drop_cnt_o=2, cnt[0]=10. Then drain with ready=1 -> 8 records with consecutive timestamps.
- Full with simultaneous pop: with the FIFO full, assert rec_ready_i and evt_i=8'h80 together -> level stays 8, no drop, and the new record appears last after drain.
- Saturation and clear: with CNT_W=4, 20 pulses on channel 1 -> cnt[1]=15. clr_i together with another evt_i[1] pulse -> cnt[1]=0, seen_o[1]=0, and one record is still pushed.
- Reset mid-operation: with level_o=5, assert reset for 1 cycle -> all outputs 0, and the timestamp restarts at 0 after release.
- With CORE_IBEX_EVT_PRIV_TRACK_EN: priv 3->0 with no events -> one record with evt=0 and priv=0. Without the macro -> level_o stays 0.

Source files
------------

// File: rtl/core_ibex_event_recorder.sv
// Core event recorder: per-channel counters, sticky flags and a time-stamped record FIFO.
// Optional CORE_IBEX_EVT_PRIV_TRACK_EN turns privilege-mode changes into implicit records.
module core_ibex_event_recorder #(
    parameter int NUM_EVT = 8,
    parameter int CNT_W   = 16,
    parameter int DEPTH   = 8,
    parameter int TS_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_EVT-1:0]       evt_i,
    input  logic [1:0]               priv_mode_i,
    input  logic                     clr_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [NUM_EVT-1:0]       rec_evt_o,
    output logic [TS_W-1:0]          rec_ts_o,
    output logic [1:0]               rec_priv_o,
    output logic [NUM_EVT*CNT_W-1:0] cnt_o,
    output logic [NUM_EVT-1:0]       seen_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = NUM_EVT + TS_W + 2;

    logic [RW-1:0]    mem_q [DEPTH];
    logic [RW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q [NUM_EVT];
    logic [CNT_W-1:0] cnt_d [NUM_EVT];
    logic [NUM_EVT-1:0] seen_q, seen_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic push_req, push, pop, full, drop;

`ifdef CORE_IBEX_EVT_PRIV_TRACK_EN
    logic [1:0] prev_priv_q;
    logic       started_q;
    // The first sampled mode after reset is a baseline, not a change.
    assign push_req = (|evt_i) | (started_q & (priv_mode_i != prev_priv_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_priv_q <= 2'd0;
            started_q   <= 1'b0;
        end else begin
            prev_priv_q <= priv_mode_i;
            started_q   <= 1'b1;
        end
    end
`else
    assign push_req = |evt_i;
`endif

    assign full = (level_q == LW'(DEPTH));
    assign pop  = rec_ready_i & (level_q != '0);
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = {evt_i, ts_q, priv_mode_i};
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        ts_d    = ts_q + 1'b1;
        for (int k = 0; k < NUM_EVT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_i) cnt_d[k] = '0;
            else if (evt_i[k] && cnt_q[k] != {CNT_W{1'b1}})
                cnt_d[k] = cnt_q[k] + 1'b1;
        end
        seen_d = clr_i ? '0 : (seen_q | evt_i);
        drop_d = drop_q;
        if (clr_i) drop_d = '0;
        else if (drop && drop_q != {CNT_W{1'b1}}) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ts_q    <= '0;
            seen_q  <= '0;
            drop_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ts_q    <= ts_d;
            seen_q  <= seen_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!$isunknown(evt_i));
    end

    assign rec_valid_o = (level_q != '0);
    assign rec_evt_o   = mem_q[rptr_q][RW-1 -: NUM_EVT];
    assign rec_ts_o    = mem_q[rptr_q][2 +: TS_W];
    assign rec_priv_o  = mem_q[rptr_q][1:0];
    assign seen_o      = seen_q;
    assign drop_cnt_o  = drop_q;
    assign level_o     = level_q;

    for (genvar k = 0; k < NUM_EVT; k++) begin : g_cnt
        assign cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end

endmodule

// File: tb/tb_core_ibex_event_recorder.sv
// Scoreboard bench for core_ibex_event_recorder (NUM_EVT=8, CNT_W=4, DEPTH=8).
module tb_core_ibex_event_recorder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  evt = '0;
    logic [1:0]  priv = 2'd3;
    logic        clr = 1'b0;
    logic        ready = 1'b0;
    logic        rec_valid;
    logic [7:0]  rec_evt;
    logic [31:0] rec_ts;
    logic [1:0]  rec_priv;
    logic [31:0] cnt;
    logic [7:0]  seen;
    logic [3:0]  drop_cnt;
    logic [3:0]  level;

    logic [31:0] mts;
    logic [41:0] sb [$];
    int n_tests = 0;
    int n_fail  = 0;

    core_ibex_event_recorder #(
        .NUM_EVT(8), .CNT_W(4), .DEPTH(8), .TS_W(32)
    ) dut (
        .clk(clk), .reset(reset), .evt_i(evt), .priv_mode_i(priv),
        .clr_i(clr), .rec_valid_o(rec_valid), .rec_ready_i(ready),
        .rec_evt_o(rec_evt), .rec_ts_o(rec_ts), .rec_priv_o(rec_priv),
        .cnt_o(cnt), .seen_o(seen), .drop_cnt_o(drop_cnt), .level_o(level)
    );

    always #5 clk = ~clk;

    // Reference timestamp: cycles since reset release.
    always @(posedge clk or posedge reset)
        if (reset) mts <= '0;
        else mts <= mts + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One-cycle pulse; accepted records go into the scoreboard first.
    task automatic ev(input logic [7:0] e, input bit acc, input logic c);
        if (acc) sb.push_back({e, mts, priv});
        evt = e;
        clr = c;
        @(posedge clk);
        #1;
        evt = '0;
        clr = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every handshake pops one expected record.
    initial begin
        logic [41:0] e;
        forever begin
            @(negedge clk);
            if (!reset && rec_valid && ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rec", {rec_evt, rec_ts, rec_priv}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rec_evt", rec_evt, e[41:34]);
                    chk("rec_ts", rec_ts, e[33:2]);
                    chk("rec_priv", rec_priv, e[1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_valid", rec_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_seen", seen, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single event at ts 5
        cyc(5);
        sb.push_back({8'h04, 32'd5, 2'd3});
        ev(8'h04, 0, 0);
        chk("t1_valid", rec_valid, 1);
        chk("t1_level", level, 1);
        chk("t1_cnt2", cnt[8 +: 4], 1);
        chk("t1_seen", seen, 8'h04);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        chk("t1_empty", level, 0);

        // overflow: 10 pushes into depth 8
        for (int i = 0; i < 10; i++) ev(8'h01, i < 8, 0);
        chk("ovf_level", level, 8);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_cnt0", cnt[0 +: 4], 10);

        // full with simultaneous pop
        ready = 1'b1;
        ev(8'h80, 1, 0);
        ready = 1'b0;
        chk("fp_level", level, 8);
        chk("fp_drop", drop_cnt, 2);
        ready = 1'b1;
        cyc(8);
        ready = 1'b0;
        chk("fp_drain", level, 0);
        chk("fp_sb", sb.size(), 0);

        // saturation, then clear racing an increment
        ready = 1'b1;
        for (int i = 0; i < 20; i++) ev(8'h02, 1, 0);
        chk("sat_cnt1", cnt[4 +: 4], 15);
        chk("sat_cnt0", cnt[0 +: 4], 10);
        ev(8'h02, 1, 1);
        chk("clr_cnt1", cnt[4 +: 4], 0);
        chk("clr_cnt0", cnt[0 +: 4], 0);
        chk("clr_seen", seen, 0);
        chk("clr_drop", drop_cnt, 0);
        chk("clr_level", level, 1);
        cyc(3);
        ready = 1'b0;
        chk("clr_drain", level, 0);

        // reset mid-operation
        for (int i = 0; i < 5; i++) ev(8'h10, 0, 0);
        chk("mr_level5", level, 5);
        reset = 1'b1;
        #1;
        chk("mr_valid", rec_valid, 0);
        chk("mr_level", level, 0);
        chk("mr_cnt", cnt, 0);
        chk("mr_seen", seen, 0);
        chk("mr_rec", {rec_evt, rec_ts, rec_priv}, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.push_back({8'h20, 32'd0, 2'd3});
        ev(8'h20, 0, 0);
        ready = 1'b1;
        cyc(2);
        ready = 1'b0;
        chk("mr_drain", level, 0);

        // privilege change with no events
`ifdef CORE_IBEX_EVT_PRIV_TRACK_EN
        sb.push_back({8'h00, mts, 2'd0});
        priv = 2'd0;
        cyc(1);
        chk("priv_level", level, 1);
        ready = 1'b1;
        cyc(2);
        ready = 1'b0;
`else
        priv = 2'd0;
        cyc(2);
        chk("priv_level", level, 0);
`endif
        chk("final_sb", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
